mult_result_drain: RTL
======================

// Module: mult_result_drain
// PURPOSE
//  Drain end of the multiplier pipeline: takes the carry-save word set leaving the last mult latch stage.
//  Resolves it to a 64-bit product with a 2-stage split adder (low 32, then high 32 with carry).
//  Buffers results in a FIFO with a valid/ready handshake toward writeback.
//  Upstream latches cannot stall, so the block exports almost_full to issue control.
//  Drops on overflow are flagged sticky.
// PARAMETERS
//  DEPTH     4  FIFO entries (power of 2, >=4)
//  TAG_W     5  destination-register tag width
//  AF_FREE   2  almost_full asserts when free entries <= AF_FREE (covers the 2 in-flight adder stages)
// PORTS
//  clock        in   1      rising-edge clock
//  reset_n      in   1      asynchronous, active-low reset
//  in_valid     in   1      word set valid this cycle (no backpressure upstream)
//  in_sum_lo    in   32     sum vector [31:0]
//  in_sum_hi    in   32     sum vector [63:32]
//  in_cry_lo    in   32     carry vector [31:0]
//  in_cry_hi    in   32     carry vector [63:32]
//  in_tag       in   TAG_W  destination tag, travels with the data
//  out_valid    out  1      FIFO head valid
//  out_ready    in   1      writeback accepts head
//  out_product  out  64     {sum_hi,sum_lo}+{cry_hi,cry_lo} mod 2^64
//  out_ovf      out  1      product does not fit signed 32 (hi != {32{lo[31]}})
//  out_tag      out  TAG_W  tag of head entry
//  almost_full  out  1      free entries <= AF_FREE
//  overflow_err out  1      sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (reset_n=0, async): both adder stages invalid, FIFO empty, all outputs 0.
//  Outputs: out_valid=0, out_product=0, out_ovf=0, out_tag=0, almost_full=0, overflow_err=0.
//  Stage A, edge E0: if in_valid, register lo = sum_lo+cry_lo (32b) and c32 = carry-out.
//   Also register sum_hi, cry_hi, tag, and vA=1; otherwise vA=0.
//  Stage B, edge E1: if vA, hi = sum_hi+cry_hi+c32 mod 2^32; register {hi,lo}, ovf and tag; vB=1.
//  FIFO, edge E2: if vB, push {product,ovf,tag}. out_valid rises after E2 when the FIFO was empty.
//   Latency is 3 edges, throughput 1 result per cycle.
//  Handshake: pop on an edge where out_valid && out_ready.
//   out_* are driven from the FIFO head (registered storage, no combinational path from in_*).
//   Head is stable while out_valid && !out_ready.
//  Simultaneous push+pop: count unchanged, always legal, including when full.
//  Push when full and no pop: entry dropped, FIFO contents unchanged, overflow_err<=1.
//   overflow_err is cleared only by reset.
//  Pop when empty: ignored, count stays 0.
//  Read/write pointers are log2(DEPTH) bits and wrap naturally. count range is 0..DEPTH.
//  almost_full is combinational from count: (DEPTH-count) <= AF_FREE.
//  Reset mid-operation: in-flight stage contents and FIFO contents are discarded immediately.
//   No output glitches to stale data after reset_n deasserts.
// TESTING
//  1 Single op: sum=64'h0000_0000_FFFF_FFFF, cry=64'h1 -> after 3 edges:
//    out_product=64'h1_0000_0000 (carry crosses 32), out_ovf=1, tag preserved.
//  2 Sign fit: sum=64'hFFFF_FFFF_FFFF_FFF0, cry=64'h8 -> product 64'hFFFF_FFFF_FFFF_FFF8, out_ovf=0.
//  3 Back-to-back: 8 consecutive in_valid with tags 0..7, out_ready=1 -> 8 results in order,
//    one per cycle, no gaps after the first; almost_full never asserts.
//  4 Fill/overflow: out_ready=0, 6 pushes (DEPTH=4) -> almost_full after 2nd write;
//    overflow_err=1 on the 5th write; head stays tag 0; draining yields tags 0..3 only.
//  5 Full + simultaneous push/pop: FIFO full, out_ready=1 while a result arrives ->
//    no drop, overflow_err stays 0, count stays 4.
//  6 Async reset mid-stream: assert reset_n=0 between edges with 3 entries queued ->
//    all outputs 0 immediately; after release a new op emerges exactly 3 edges later.

Source files
------------

// File: rtl/mult_result_drain.sv
// Resolves carry-save multiplier output to a 64-bit product and queues it for writeback.
// Latency 3 edges in to out_valid; no upstream stall, almost_full warns issue, full drops are sticky-flagged.
module mult_result_drain #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5,
  parameter int AF_FREE = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [31:0]      in_sum_lo,
  input  logic [31:0]      in_sum_hi,
  input  logic [31:0]      in_cry_lo,
  input  logic [31:0]      in_cry_hi,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_product,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             almost_full,
  output logic             overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_FREE_C = CNT_W'(AF_FREE);

  typedef struct packed {
    logic [63:0]      product;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Stage A: low half resolved, high half operands carried forward
  logic             va_q, va_d;
  logic [31:0]      lo_q, lo_d;
  logic             c32_q, c32_d;
  logic [31:0]      sum_hi_q, sum_hi_d;
  logic [31:0]      cry_hi_q, cry_hi_d;
  logic [TAG_W-1:0] tag_a_q, tag_a_d;

  // Stage B: complete entry ready to push
  logic             vb_q, vb_d;
  entry_t           ent_b_q, ent_b_d;

  // FIFO state
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_err_q, ovf_err_d;

  logic             do_push;
  logic             do_pop;
  logic             full;
  logic [32:0]      lo_sum;
  logic [31:0]      hi_sum;
  entry_t           head;

  always_comb begin
    lo_sum   = {1'b0, in_sum_lo} + {1'b0, in_cry_lo};
    va_d     = in_valid;
    lo_d     = lo_q;
    c32_d    = c32_q;
    sum_hi_d = sum_hi_q;
    cry_hi_d = cry_hi_q;
    tag_a_d  = tag_a_q;
    if (in_valid) begin
      lo_d     = lo_sum[31:0];
      c32_d    = lo_sum[32];
      sum_hi_d = in_sum_hi;
      cry_hi_d = in_cry_hi;
      tag_a_d  = in_tag;
    end
  end

  always_comb begin
    hi_sum  = sum_hi_q + cry_hi_q + {31'b0, c32_q};
    vb_d    = va_q;
    ent_b_d = ent_b_q;
    if (va_q) begin
      ent_b_d.product = {hi_sum, lo_q};
      ent_b_d.ovf     = (hi_sum != {32{lo_q[31]}});
      ent_b_d.tag     = tag_a_q;
    end
  end

  // A push into a full FIFO is still accepted when the head leaves on the same edge
  always_comb begin
    full      = (count_q == DEPTH_C);
    do_pop    = out_valid && out_ready;
    do_push   = vb_q && (!full || do_pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop);
    count_d   = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    ovf_err_d = ovf_err_q || (vb_q && full && !do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      va_q      <= 1'b0;
      lo_q      <= '0;
      c32_q     <= 1'b0;
      sum_hi_q  <= '0;
      cry_hi_q  <= '0;
      tag_a_q   <= '0;
      vb_q      <= 1'b0;
      ent_b_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      va_q      <= va_d;
      lo_q      <= lo_d;
      c32_q     <= c32_d;
      sum_hi_q  <= sum_hi_d;
      cry_hi_q  <= cry_hi_d;
      tag_a_q   <= tag_a_d;
      vb_q      <= vb_d;
      ent_b_q   <= ent_b_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= ent_b_q;
    end
  end

  // Head fields are masked while empty so stale storage never reaches the outputs
  always_comb begin
    head         = mem_q[rd_ptr_q];
    out_valid    = (count_q != '0);
    out_product  = out_valid ? head.product : 64'b0;
    out_ovf      = out_valid ? head.ovf : 1'b0;
    out_tag      = out_valid ? head.tag : '0;
    almost_full  = ((DEPTH_C - count_q) <= AF_FREE_C);
    overflow_err = ovf_err_q;
  end

endmodule
